// File: rtl/vga_pos_fetch_sched.sv
// Port-B scheduler for the VGA side: loads sprite positions once per frame on
// vblank start and serves single-word secondary reads in between.
module vga_pos_fetch_sched #(
    parameter logic [15:0] POS_BASE  = 16'h0100,
    parameter int          NUM_WORDS = 4,
    parameter int          RD_LAT    = 2
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      vblank_pix,
    output logic [15:0]               ram_addr_b,
    input  logic [15:0]               ram_q_b,
    input  logic                      req_valid,
    input  logic [15:0]               req_addr,
    output logic                      req_ready,
    output logic                      rsp_valid,
    output logic [15:0]               rsp_data,
    output logic [16*NUM_WORDS-1:0]   pos_words,
    output logic                      commit_pulse,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      clr_overrun
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int LAT_W = 3;

    typedef enum logic [2:0] {IDLE, L_ISSUE, L_WAIT, COMMIT, S_ISSUE, S_WAIT} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [LAT_W-1:0]             lat_q, lat_d;
    logic [15:0]                  addr_q, addr_d;
    logic [NUM_WORDS-1:0][15:0]   shadow_q, shadow_d;
    logic [NUM_WORDS-1:0][15:0]   pos_q, pos_d;
    logic [15:0]                  rsp_data_q, rsp_data_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         commit_q, commit_d;
    logic                         overrun_q, overrun_d;
    logic                         pending_q, pending_d;
    logic                         s1_q, s2_q, s3_q;
    logic                         vb_start, loading, lat_done;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= vblank_pix;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign vb_start = s2_q & ~s3_q;
    assign loading  = (state_q == L_ISSUE) || (state_q == L_WAIT) || (state_q == COMMIT);
    assign lat_done = (lat_q == LAT_W'(RD_LAT));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        addr_d      = addr_q;
        shadow_d    = shadow_q;
        pos_d       = pos_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        commit_d    = 1'b0;
        pending_d   = pending_q;
        overrun_d   = clr_overrun ? 1'b0 : overrun_q;

        unique case (state_q)
            IDLE: begin
                // The frame load always wins a tie with a secondary request.
                if (pending_q || vb_start) begin
                    addr_d    = POS_BASE;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = L_ISSUE;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = S_ISSUE;
                end
            end
            L_ISSUE: begin
                lat_d   = LAT_W'(1);
                state_d = L_WAIT;
            end
            L_WAIT: begin
                if (lat_done) begin
                    shadow_d[idx_q] = ram_q_b;
                    if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                        commit_d = 1'b1;
                        state_d  = COMMIT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = addr_q + 16'd1;
                        state_d = L_ISSUE;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            COMMIT: begin
                pos_d   = shadow_q;
                state_d = IDLE;
            end
            S_ISSUE: begin
                lat_d   = LAT_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_done) begin
                    rsp_data_d  = ram_q_b;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A secondary access is never aborted; remember the frame edge instead.
        if (vb_start && (state_q == S_ISSUE || state_q == S_WAIT))
            pending_d = 1'b1;
        if (vb_start && loading)
            overrun_d = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lat_q       <= '0;
            addr_q      <= POS_BASE;
            shadow_q    <= '0;
            pos_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            commit_q    <= 1'b0;
            overrun_q   <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            pos_q       <= pos_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            commit_q    <= commit_d;
            overrun_q   <= overrun_d;
            pending_q   <= pending_d;
        end
    end

    assign ram_addr_b   = addr_q;
    assign req_ready    = (state_q == IDLE) && !pending_q && !vb_start;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign pos_words    = pos_q;
    assign commit_pulse = commit_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_vga_pos_fetch_sched.sv
// Directed bench: default instance plus two parameter-corner instances, each
// driven by a simple fixed-latency RAM model.
module tb_vga_pos_fetch_sched;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] vb;
    logic req_valid, clr_ovr;
    logic [15:0] req_addr;

    logic [15:0] a0, a1, a2, q0, q1, q2, rd0;
    logic        rdy0, rdy1, rdy2, rv0, rv1, rv2, cp0, cp1, cp2;
    logic        bz0, bz1, bz2, ov0, ov1, ov2;
    logic [15:0] rd1, rd2;
    logic [63:0] pw0;
    logic [15:0] pw1;
    logic [31:0] pw2;

    logic [15:0] m0a, m0b, m1a, m2a, m2b;

    int n_chk = 0;
    int n_fail = 0;
    int ncommit;

    always #10 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0100: return 16'h00C8;
            16'h0101: return 16'h0190;
            16'h0102: return 16'h0011;
            16'h0103: return 16'h0022;
            16'h0200: return 16'hBEEF;
            16'hFFFF: return 16'h1234;
            16'h0000: return 16'h5678;
            default:  return ~a;
        endcase
    endfunction

    // RAM models: data for the address present in cycle T is valid in T+RD_LAT.
    always @(posedge clk) begin
        m0a <= mem(a0); m0b <= m0a;
        m1a <= mem(a1);
        m2a <= mem(a2); m2b <= m2a;
    end
    assign q0 = m0b;
    assign q1 = m1a;
    assign q2 = m2b;

    vga_pos_fetch_sched dut0 (
        .sys_clk(clk), .reset(rst), .vblank_pix(vb[0]), .ram_addr_b(a0), .ram_q_b(q0),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy0), .rsp_valid(rv0),
        .rsp_data(rd0), .pos_words(pw0), .commit_pulse(cp0), .busy(bz0), .overrun(ov0),
        .clr_overrun(clr_ovr));

    vga_pos_fetch_sched #(.POS_BASE(16'hFFFF), .NUM_WORDS(1), .RD_LAT(1)) dut1 (
        .sys_clk(clk), .reset(rst), .vblank_pix(vb[1]), .ram_addr_b(a1), .ram_q_b(q1),
        .req_valid(1'b0), .req_addr(16'h0000), .req_ready(rdy1), .rsp_valid(rv1),
        .rsp_data(rd1), .pos_words(pw1), .commit_pulse(cp1), .busy(bz1), .overrun(ov1),
        .clr_overrun(1'b0));

    vga_pos_fetch_sched #(.POS_BASE(16'hFFFF), .NUM_WORDS(2), .RD_LAT(2)) dut2 (
        .sys_clk(clk), .reset(rst), .vblank_pix(vb[2]), .ram_addr_b(a2), .ram_q_b(q2),
        .req_valid(1'b0), .req_addr(16'h0000), .req_ready(rdy2), .rsp_valid(rv2),
        .rsp_data(rd2), .pos_words(pw2), .commit_pulse(cp2), .busy(bz2), .overrun(ov2),
        .clr_overrun(1'b0));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [63:0] POS_EXP = 64'h0022_0011_0190_00C8;

    initial begin
        rst = 1'b1; vb = 3'b000; req_valid = 1'b0; req_addr = 16'h0; clr_ovr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // reset state
        chk("rst_addr", a0, 16'h0100);
        chk("rst_pos", pw0, 64'h0);
        chk("rst_busy", bz0, 1'b0);
        chk("rst_rsp_valid", rv0, 1'b0);
        chk("rst_overrun", ov0, 1'b0);
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_addr_corner", a1, 16'hFFFF);

        // 1: basic frame load
        vb[0] = 1'b1;
        tick(2);
        ncommit = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k <= 12) chk($sformatf("load_addr_k%0d", k), a0, 16'h0100 + 16'((k - 1) / 3));
            if (k == 12) chk("load_no_commit_early", cp0, 1'b0);
            if (k == 13) begin
                chk("load_commit", cp0, 1'b1);
                chk("load_pos_before_commit", pw0, 64'h0);
            end
            if (k == 14) begin
                chk("load_pos", pw0, POS_EXP);
                chk("load_commit_end", cp0, 1'b0);
                chk("load_idle", bz0, 1'b0);
            end
        end
        vb[0] = 1'b0;
        tick(4);

        // 2: secondary read
        req_valid = 1'b1; req_addr = 16'h0200;
        chk("sec_ready", rdy0, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("sec_addr", a0, 16'h0200);
        tick(2);
        chk("sec_rsp_early", rv0, 1'b0);
        tick();
        chk("sec_rsp_valid", rv0, 1'b1);
        chk("sec_rsp_data", rd0, 16'hBEEF);
        tick();
        chk("sec_rsp_pulse", rv0, 1'b0);
        chk("sec_rsp_hold", rd0, 16'hBEEF);

        // 3: tie between vb_start and a request
        vb[0] = 1'b1;
        tick(2);
        req_valid = 1'b1; req_addr = 16'h0201;
        chk("tie_ready_low", rdy0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) chk("tie_load_first", a0, 16'h0100);
            if (k == 13) begin
                chk("tie_commit", cp0, 1'b1);
                chk("tie_ready_busy", rdy0, 1'b0);
            end
            if (k == 14) chk("tie_ready_after", rdy0, 1'b1);
        end
        tick();
        req_valid = 1'b0;
        chk("tie_sec_addr", a0, 16'h0201);
        tick(3);
        chk("tie_rsp_valid", rv0, 1'b1);
        chk("tie_rsp_data", rd0, 16'hFDFE);
        vb[0] = 1'b0;
        tick(4);

        // 4: vblank during a secondary access
        req_valid = 1'b1; req_addr = 16'h0300; vb[0] = 1'b1;
        chk("vbs_ready", rdy0, 1'b1);
        tick();
        req_valid = 1'b0;
        tick(3);
        chk("vbs_rsp_valid", rv0, 1'b1);
        chk("vbs_rsp_data", rd0, 16'hFCFF);
        chk("vbs_ready_pending", rdy0, 1'b0);
        tick();
        chk("vbs_load_addr", a0, 16'h0100);
        chk("vbs_load_busy", bz0, 1'b1);
        tick(13);
        chk("vbs_done", bz0, 1'b0);
        chk("vbs_overrun", ov0, 1'b0);
        vb[0] = 1'b0;
        tick(4);

        // 5: overrun, then clear
        vb[0] = 1'b1;
        tick(2);
        tick(3);
        vb[0] = 1'b0;
        tick();
        vb[0] = 1'b1;
        ncommit = 0;
        for (int k = 5; k <= 20; k++) begin
            tick();
            if (cp0) ncommit++;
            if (k == 10) chk("ovr_set", ov0, 1'b1);
        end
        chk("ovr_one_commit", ncommit, 1);
        chk("ovr_pos", pw0, POS_EXP);
        chk("ovr_idle", bz0, 1'b0);
        chk("ovr_sticky", ov0, 1'b1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clear", ov0, 1'b0);
        vb[0] = 1'b0;
        tick(4);

        // 5b: reset mid-load
        vb[0] = 1'b1;
        tick(2);
        tick(5);
        rst = 1'b1; vb[0] = 1'b0;
        #1;
        chk("rstm_pos", pw0, 64'h0);
        chk("rstm_addr", a0, 16'h0100);
        chk("rstm_busy", bz0, 1'b0);
        tick(2);
        rst = 1'b0;
        ncommit = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cp0) ncommit++;
        end
        chk("rstm_no_commit", ncommit, 0);
        chk("rstm_pos_after", pw0, 64'h0);

        // 6: parameter corners
        vb[2:1] = 2'b11;
        tick(2);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                chk("c1_addr", a1, 16'hFFFF);
                chk("c2_addr_w0", a2, 16'hFFFF);
            end
            if (k == 2) chk("c1_no_commit", cp1, 1'b0);
            if (k == 3) chk("c1_commit", cp1, 1'b1);
            if (k == 4) begin
                chk("c1_pos", pw1, 16'h1234);
                chk("c2_addr_wrap", a2, 16'h0000);
            end
            if (k == 7) chk("c2_commit", cp2, 1'b1);
            if (k == 8) chk("c2_pos", pw2, 32'h5678_1234);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
